// File: rtl/rotor_pkg.sv
// Shared types and default timing constants for the birdhouse lid servo.
package rotor_pkg;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } rotor_state_t;

    // Defaults assume a 100 MHz clock and a standard 50 Hz hobby servo.
    localparam int DEF_PERIOD_CYCLES = 2_000_000;
    localparam int DEF_PULSE_MIN     = 100_000;
    localparam int DEF_PULSE_MAX     = 200_000;
    localparam int DEF_STEP          = 2_000;
    localparam int DEF_HOLD_FRAMES   = 50;

endpackage

// File: rtl/rotor_servo_frame_timer.sv
// servo_frame_timer: free-running PWM frame counter with a one-cycle strobe on the last cycle of each frame.
module servo_frame_timer
    import rotor_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int W             = $clog2(PERIOD_CYCLES + 1)
) (
    input  logic         clock,
    input  logic         reset,
    output logic [W-1:0] fc,
    output logic         boundary
);

    localparam logic [W-1:0] LAST = W'(PERIOD_CYCLES - 1);

    assign boundary = (fc == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fc <= '0;
        end else if (boundary) begin
            fc <= '0;
        end else begin
            fc <= fc + W'(1);
        end
    end

endmodule

// File: rtl/rotor_servo.sv
// Rate-limited hobby-servo driver for the birdhouse lid rotor flag.
// Define ROTOR_SERVO_HOLD_EN to keep the lid open for at least HOLD_FRAMES frames.
module rotor_servo
    import rotor_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int PULSE_MIN     = DEF_PULSE_MIN,
    parameter int PULSE_MAX     = DEF_PULSE_MAX,
    parameter int STEP          = DEF_STEP,
    parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES
) (
    input  logic clock,
    input  logic reset,
    input  logic rotor_req,
    output logic pwm,
    output logic busy,
    output logic at_open,
    output logic at_closed
);

    localparam int W = $clog2(PERIOD_CYCLES + 1);
    localparam logic [W-1:0] PW_MIN = W'(PULSE_MIN);
    localparam logic [W-1:0] PW_MAX = W'(PULSE_MAX);

    generate
        if (!(PULSE_MIN < PULSE_MAX && PULSE_MAX < PERIOD_CYCLES && STEP >= 1 && HOLD_FRAMES >= 0)) begin : g_param_check
            $fatal(1, "rotor_servo: need PULSE_MIN < PULSE_MAX < PERIOD_CYCLES and STEP >= 1");
        end
    endgenerate

    // Move one frame toward the target, landing exactly on it when within STEP.
    function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            ramp_step = (32'(diff) <= STEP) ? tgt : cur + W'(STEP);
        end else begin
            diff = cur - tgt;
            ramp_step = (32'(diff) <= STEP) ? tgt : cur - W'(STEP);
        end
    endfunction

    logic [W-1:0] fc;
    logic         boundary;
    logic [W-1:0] pw, pw_nxt;
    rotor_state_t state, state_nxt;
    logic         req_eff;

    servo_frame_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .W            (W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .fc      (fc),
        .boundary(boundary)
    );

`ifdef ROTOR_SERVO_HOLD_EN
    localparam int HW = $clog2(HOLD_FRAMES + 2);
    logic [HW-1:0] hold;

    // While the hold is pending an OPEN lid behaves as if the request were still high.
    assign req_eff = rotor_req | ((state == OPEN) && (hold != '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (boundary) begin
            if (state != OPEN && state_nxt == OPEN) begin
                hold <= HW'(HOLD_FRAMES);
            end else if (state == OPEN && hold != '0) begin
                hold <= hold - HW'(1);
            end
        end
    end
`else
    assign req_eff = rotor_req;
`endif

    always_comb begin
        pw_nxt    = pw;
        state_nxt = state;
        if (boundary) begin
            pw_nxt = ramp_step(pw, req_eff ? PW_MAX : PW_MIN);
            case (state)
                CLOSED: begin
                    if (req_eff) state_nxt = (pw_nxt == PW_MAX) ? OPEN : OPENING;
                end
                OPENING: begin
                    if (!req_eff)              state_nxt = (pw_nxt == PW_MIN) ? CLOSED : CLOSING;
                    else if (pw_nxt == PW_MAX) state_nxt = OPEN;
                end
                OPEN: begin
                    if (!req_eff) state_nxt = (pw_nxt == PW_MIN) ? CLOSED : CLOSING;
                end
                CLOSING: begin
                    if (req_eff)               state_nxt = (pw_nxt == PW_MAX) ? OPEN : OPENING;
                    else if (pw_nxt == PW_MIN) state_nxt = CLOSED;
                end
                default: state_nxt = CLOSED;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= CLOSED;
            pw    <= PW_MIN;
            pwm   <= 1'b0;
        end else begin
            state <= state_nxt;
            pw    <= pw_nxt;
            pwm   <= (fc < pw);
        end
    end

    assign busy      = (state == OPENING) || (state == CLOSING);
    assign at_open   = (state == OPEN);
    assign at_closed = (state == CLOSED);

endmodule

// File: tb/tb_rotor_servo.sv
// Directed bench for rotor_servo: frame-by-frame pulse widths and status flags.
module tb_rotor_servo;

    localparam int P = 100;

    logic clock = 1'b0;
    logic reset, reset_c;
    logic rotor_req, req_c;
    logic pwm, busy, at_open, at_closed;
    logic pwm_c, busy_c, open_c, closed_c;

    always #5 clock = ~clock;

    rotor_servo #(
        .PERIOD_CYCLES(100), .PULSE_MIN(10), .PULSE_MAX(30), .STEP(5), .HOLD_FRAMES(3)
    ) dut (
        .clock(clock), .reset(reset), .rotor_req(rotor_req),
        .pwm(pwm), .busy(busy), .at_open(at_open), .at_closed(at_closed)
    );

    rotor_servo #(
        .PERIOD_CYCLES(100), .PULSE_MIN(10), .PULSE_MAX(30), .STEP(7), .HOLD_FRAMES(3)
    ) dut_clamp (
        .clock(clock), .reset(reset_c), .rotor_req(req_c),
        .pwm(pwm_c), .busy(busy_c), .at_open(open_c), .at_closed(closed_c)
    );

    typedef struct {
        bit req;
        int hi;
        bit busy;
        bit open;
        bit closed;
    } vec_t;

    vec_t main_tab[14];
    vec_t clamp_tab[4];
    vec_t pre_tab[3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full frame; sampled #1 after each rising edge. pulse_at raises rotor_req for that single cycle.
    task automatic measure(input bit clamp, input int pulse_at, output int hi, output int first);
        hi = 0;
        first = -1;
        for (int i = 0; i < P; i++) begin
            if (i == pulse_at) rotor_req = 1'b1;
            @(posedge clock);
            #1;
            if (i == pulse_at) rotor_req = 1'b0;
            if ((clamp ? pwm_c : pwm) == 1'b1) begin
                if (first < 0) first = i;
                hi++;
            end
        end
    endtask

    task automatic run_row(input bit clamp, input vec_t v, input string tag);
        int hi, first;
        if (clamp) req_c = v.req; else rotor_req = v.req;
        measure(clamp, -1, hi, first);
        check($sformatf("%s high", tag), hi, v.hi);
        check($sformatf("%s first", tag), first, 0);
        check($sformatf("%s busy", tag), int'(clamp ? busy_c : busy), int'(v.busy));
        check($sformatf("%s at_open", tag), int'(clamp ? open_c : at_open), int'(v.open));
        check($sformatf("%s at_closed", tag), int'(clamp ? closed_c : at_closed), int'(v.closed));
    endtask

    initial begin
        int hi, first;

        // Reversal at pw=20, then a full open sweep and a release from OPEN.
        main_tab[0]  = '{1'b1, 10, 1'b1, 1'b0, 1'b0};
        main_tab[1]  = '{1'b1, 15, 1'b1, 1'b0, 1'b0};
        main_tab[2]  = '{1'b0, 20, 1'b1, 1'b0, 1'b0};
        main_tab[3]  = '{1'b0, 15, 1'b0, 1'b0, 1'b1};
        main_tab[4]  = '{1'b0, 10, 1'b0, 1'b0, 1'b1};
        main_tab[5]  = '{1'b1, 10, 1'b1, 1'b0, 1'b0};
        main_tab[6]  = '{1'b1, 15, 1'b1, 1'b0, 1'b0};
        main_tab[7]  = '{1'b1, 20, 1'b1, 1'b0, 1'b0};
        main_tab[8]  = '{1'b1, 25, 1'b0, 1'b1, 1'b0};
        main_tab[9]  = '{1'b1, 30, 1'b0, 1'b1, 1'b0};
        main_tab[10] = '{1'b1, 30, 1'b0, 1'b1, 1'b0};
`ifdef ROTOR_SERVO_HOLD_EN
        main_tab[11] = '{1'b0, 30, 1'b0, 1'b1, 1'b0};
        main_tab[12] = '{1'b0, 30, 1'b1, 1'b0, 1'b0};
        main_tab[13] = '{1'b0, 25, 1'b1, 1'b0, 1'b0};
`else
        main_tab[11] = '{1'b0, 30, 1'b1, 1'b0, 1'b0};
        main_tab[12] = '{1'b0, 25, 1'b1, 1'b0, 1'b0};
        main_tab[13] = '{1'b0, 20, 1'b1, 1'b0, 1'b0};
`endif
        clamp_tab[0] = '{1'b1, 10, 1'b1, 1'b0, 1'b0};
        clamp_tab[1] = '{1'b1, 17, 1'b1, 1'b0, 1'b0};
        clamp_tab[2] = '{1'b1, 24, 1'b0, 1'b1, 1'b0};
        clamp_tab[3] = '{1'b1, 30, 1'b0, 1'b1, 1'b0};
        pre_tab[0]   = '{1'b1, 10, 1'b1, 1'b0, 1'b0};
        pre_tab[1]   = '{1'b1, 15, 1'b1, 1'b0, 1'b0};
        pre_tab[2]   = '{1'b1, 20, 1'b1, 1'b0, 1'b0};

        reset     = 1'b0;
        reset_c   = 1'b0;
        rotor_req = 1'b0;
        req_c     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset pwm", int'(pwm), 0);
        check("reset busy", int'(busy), 0);
        check("reset at_open", int'(at_open), 0);
        check("reset at_closed", int'(at_closed), 1);

        // STEP=7 instance: 10 -> 17 -> 24 -> 30 with no overshoot.
        @(negedge clock);
        reset_c = 1'b1;
        for (int i = 0; i < 4; i++) run_row(1'b1, clamp_tab[i], $sformatf("clamp%0d", i));
        reset_c = 1'b0;
        #1;
        check("clamp reset at_closed", int'(closed_c), 1);

        @(negedge clock);
        check("held reset at_closed", int'(at_closed), 1);
        reset = 1'b1;
        check("release pwm", int'(pwm), 0);
        for (int i = 0; i < 14; i++) run_row(1'b0, main_tab[i], $sformatf("main%0d", i));

        // Reset in the middle of an opening sweep with pw=25.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) run_row(1'b0, pre_tab[i], $sformatf("pre%0d", i));
        repeat (10) @(posedge clock);
        #1;
        check("mid pwm before reset", int'(pwm), 1);
        check("mid busy before reset", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid reset pwm", int'(pwm), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset at_open", int'(at_open), 0);
        check("mid reset at_closed", int'(at_closed), 1);
        @(negedge clock);
        reset = 1'b1;
        run_row(1'b0, '{1'b0, 10, 1'b0, 1'b0, 1'b1}, "post");

        // A request pulse between boundaries is ignored; one on the boundary cycle is taken.
        rotor_req = 1'b0;
        measure(1'b0, 50, hi, first);
        check("mid-frame pulse high", hi, 10);
        check("mid-frame pulse at_closed", int'(at_closed), 1);
        measure(1'b0, 99, hi, first);
        check("boundary pulse high", hi, 10);
        check("boundary pulse busy", int'(busy), 1);
        measure(1'b0, -1, hi, first);
        check("after pulse high", hi, 15);
        check("after pulse at_closed", int'(at_closed), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_servo.md
# rotor_servo

Downstream actuator stage for the birdhouse processor system. Consumes the one-bit rotor request driven out of the data-memory RAM's memory-mapped rotor flag and turns it into a standard hobby-servo PWM waveform. Position changes are rate-limited so the lid sweeps gradually between closed and open. Status outputs are exposed for board LEDs.

## Interface
Parameters:
- PERIOD_CYCLES, 2_000_000: PWM frame length in clock cycles (20 ms at 100 MHz).
- PULSE_MIN, 100_000: high time for the closed position (1 ms).
- PULSE_MAX, 200_000: high time for the open position (2 ms).
- STEP, 2_000: maximum pulse-width change per frame.
- HOLD_FRAMES, 50: minimum frames held in OPEN; used only when hold is compiled in.

Ports:
- clock  in  1  system clock, the same clock as the processor and RAM.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rotor_req  in  1  level from the RAM rotor flag; 1 = open, 0 = closed. Synchronous to clock.
- pwm  out  1  servo control pulse, registered.
- busy  out  1  high while sweeping (OPENING or CLOSING).
- at_open  out  1  high in OPEN.
- at_closed  out  1  high in CLOSED.

## Operation
- Frame counter fc runs 0..PERIOD_CYCLES-1 and wraps to 0.
  - Frame boundary = the cycle with fc == PERIOD_CYCLES-1.
- Pulse-width register pw is unsigned and $clog2(PERIOD_CYCLES+1) bits wide. fc uses the same width.
- pwm is registered: pwm <= (fc < pw).
- Sampling: rotor_req is sampled only at frame boundaries. Changes between boundaries are ignored until the next boundary.
- Target: target = rotor_req ? PULSE_MAX : PULSE_MIN.
- pw update at each boundary:
  - If |target - pw| <= STEP, then pw <= target (clamp, no overshoot).
  - Otherwise pw moves by STEP toward target.
- FSM states: CLOSED, OPENING, OPEN, CLOSING. Transitions are evaluated only at boundaries, using the sampled request and the new pw.
  - CLOSED, req=1 → OPENING (or OPEN if the first step reaches PULSE_MAX).
  - OPENING, new pw == PULSE_MAX → OPEN.
  - OPENING, req=0 → CLOSING. Reversal is immediate, and pw steps down at the same boundary.
  - OPEN, req=0 → CLOSING, subject to hold (see Configuration).
  - CLOSING, new pw == PULSE_MIN → CLOSED.
  - CLOSING, req=1 → OPENING.
- busy, at_open and at_closed are decoded from state. Exactly one of the three is high at any time.
- Elaboration-time check: PULSE_MIN < PULSE_MAX < PERIOD_CYCLES and STEP >= 1. A violation is a fatal error.

## Timing
- Reset values: fc=0, pw=PULSE_MIN, state=CLOSED, pwm=0, busy=0, at_open=0, at_closed=1.
- Reset is asynchronous: outputs take their reset values immediately. Release is synchronous to the next clock edge.
- First cycle after reset release: pwm is still 0 because of the register stage. pwm is then high for PULSE_MIN cycles in frame 0.
- pwm lags fc by 1 cycle.
- A pw change at a boundary takes effect in the pwm pattern of the very next frame.
- Request-to-first-motion latency: 1 to PERIOD_CYCLES cycles, depending on the request's position relative to the next boundary.
- Full sweep time: ceil((PULSE_MAX-PULSE_MIN)/STEP) frames.
- Reset asserted mid-sweep: return to CLOSED and PULSE_MIN without ramping.

## Configuration
- ROTOR_SERVO_HOLD_EN defined:
  - On entry to OPEN, a hold counter loads HOLD_FRAMES.
  - The counter decrements at each boundary.
  - OPEN → CLOSING is blocked until the counter reaches 0, even if req=0.
  - A req=1 seen during the hold does not reload the counter.
- ROTOR_SERVO_HOLD_EN undefined:
  - No hold counter exists.
  - OPEN → CLOSING happens at the first boundary that samples req=0.

## Structure
- Package rotor_pkg holds:
  - the state enum rotor_state_t (CLOSED, OPENING, OPEN, CLOSING);
  - the default timing constants.
- Sub-module servo_frame_timer holds the fc counter and frame-boundary strobe. It is reusable for other PWM outputs.
- rotor_servo holds the FSM, pw ramp, hold counter and registered pwm.

## Test plan
All scenarios use PERIOD_CYCLES=100, PULSE_MIN=10, PULSE_MAX=30, STEP=5, HOLD_FRAMES=3.
- Reset: hold reset=0, then release → pwm=0, at_closed=1, busy=0. pwm is high for exactly 10 cycles per frame, starting 1 cycle after fc=0.
- Open sweep: hold rotor_req=1 → pw goes 15, 20, 25, 30 at boundaries 1-4. busy is high until boundary 4, then at_open=1. The high time in frame 5 is 30 cycles.
- Reversal: drop rotor_req when pw=20 (OPENING) → CLOSING at the next boundary, pw 15 then 10, then at_closed=1.
- Clamp: STEP=7, rotor_req=1 → pw goes 17, 24, 30 with no overshoot. at_open is asserted at the 30 boundary.
- Hold: with ROTOR_SERVO_HOLD_EN, pulse rotor_req for one cycle → lid reaches OPEN, stays for 3 boundaries, then closes. Without the macro it closes at the first boundary after reaching OPEN.
- Mid-sweep reset: assert reset when pw=25 → immediately at_closed=1, pwm=0, busy=0. The next frame after release has a 10-cycle pulse.
